// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter in front of one shared 32-bit barrel shifter.
// The result is held in a one-entry valid/ready output slot.
module shift_arbiter #(
  parameter int unsigned PRIO_INIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [31:0] d0,
  input  logic [4:0]  sa0,
  input  logic        right0,
  input  logic        arith0,
  output logic        gnt0,
  input  logic        req1,
  input  logic [31:0] d1,
  input  logic [4:0]  sa1,
  input  logic        right1,
  input  logic        arith1,
  output logic        gnt1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sh,
  output logic        out_id
);

  localparam int unsigned DW  = 32;
  localparam int unsigned SAW = 5;

  logic           prio;
  logic           slot_free_c;
  logic           grant_c;
  logic [DW-1:0]  d_sel_c;
  logic [SAW-1:0] sa_sel_c;
  logic           right_sel_c;
  logic           arith_sel_c;
  logic [DW-1:0]  sh_c;

  // The slot can take a new result when empty or being drained this cycle.
  assign slot_free_c = !out_valid || out_ready;

  assign gnt0    = !reset && slot_free_c && req0 && (!req1 || !prio);
  assign gnt1    = !reset && slot_free_c && req1 && (!req0 ||  prio);
  assign grant_c = gnt0 || gnt1;

  // Operand mux feeding the single shared shifter.
  always_comb begin
    d_sel_c     = d0;
    sa_sel_c    = sa0;
    right_sel_c = right0;
    arith_sel_c = arith0;
    if (gnt1) begin
      d_sel_c     = d1;
      sa_sel_c    = sa1;
      right_sel_c = right1;
      arith_sel_c = arith1;
    end
  end

  always_comb begin
    sh_c = d_sel_c;
    if (!right_sel_c) begin
      sh_c = d_sel_c << sa_sel_c;
    end else if (arith_sel_c) begin
      sh_c = DW'($signed(d_sel_c) >>> sa_sel_c);
    end else begin
      sh_c = d_sel_c >> sa_sel_c;
    end
  end

  // Output slot and round-robin pointer; a grant always moves prio to the loser.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_sh    <= '0;
      out_id    <= 1'b0;
      prio      <= 1'(PRIO_INIT);
    end else if (grant_c) begin
      out_valid <= 1'b1;
      out_sh    <= sh_c;
      out_id    <= gnt1;
      prio      <= !gnt1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The module SHALL have parameter PRIO_INIT, default 0: the requester favoured first after reset (0 or 1).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port req0, input, 1 bit: requester 0 has a shift operation pending.
REQ-005 The module SHALL have ports d0 [31:0], sa0 [4:0], right0 and arith0, all inputs: requester 0 operand, shift amount, direction (1 = right) and right-shift kind (1 = arithmetic).
REQ-006 The module SHALL have port gnt0, output, 1 bit: requester 0 operation accepted this cycle.
REQ-007 The module SHALL have ports req1, d1 [31:0], sa1 [4:0], right1, arith1 (inputs) and gnt1 (output), identical in meaning to REQ-004..006 for requester 1.
REQ-008 The module SHALL have port out_valid, output, 1 bit: out_sh and out_id hold a result.
REQ-009 The module SHALL have port out_ready, input, 1 bit: the consumer accepts the result this cycle.
REQ-010 The module SHALL have port out_sh, output, 32 bits: the shift result.
REQ-011 The module SHALL have port out_id, output, 1 bit: the requester that produced out_sh.

Function
REQ-012 The module SHALL contain exactly one 32-bit shift datapath shared by both requesters.
REQ-013 The shift datapath SHALL compute: right=0 -> d << sa (zero fill, arith ignored); right=1, arith=0 -> logical right shift; right=1, arith=1 -> arithmetic right shift (sign fill from bit 31).
REQ-014 sa=0 SHALL pass d through unchanged in all modes.
REQ-015 The output slot SHALL be free when out_valid=0, or when out_valid=1 and out_ready=1.
REQ-016 gnt0 and gnt1 SHALL be combinational, mutually exclusive, and both 0 when reset=1 or the slot is not free.
REQ-017 With exactly one req asserted and the slot free, that requester SHALL be granted.
REQ-018 With both req asserted and the slot free, the requester indicated by the internal 1-bit register prio SHALL be granted.
REQ-019 After any grant to requester i, prio SHALL become the other requester (round robin); with no grant, prio SHALL hold.
REQ-020 A requester SHALL hold req and its operands stable until granted; the module SHALL NOT latch an ungranted request.
REQ-021 On a grant, out_sh SHALL load the shift result of the granted operands, out_id SHALL load the granted index, and out_valid SHALL be 1 on the next cycle: latency 1 cycle.
REQ-022 out_valid, out_sh and out_id SHALL hold unchanged while out_valid=1 and out_ready=0.
REQ-023 When out_valid=1, out_ready=1 and a grant occur in the same cycle, the new result SHALL replace the old one with out_valid staying 1, giving one result per cycle.
REQ-024 When out_valid=1, out_ready=1 and no grant occur, out_valid SHALL go to 0 and out_sh/out_id SHALL hold their last values.
REQ-025 out_ready SHALL be ignored while out_valid=0.
REQ-026 Neither requester SHALL wait more than one grant of the other requester while its req is held.

Reset
REQ-027 With reset=1 at a clock edge, the module SHALL set out_valid=0, out_sh=32'h0, out_id=0 and prio=PRIO_INIT.
REQ-028 Reset asserted mid-operation SHALL discard any held result, and the module SHALL NOT issue a grant during any reset cycle.
REQ-029 In the first cycle after reset deasserts, the module SHALL accept requests normally.

Verification
REQ-030 Single op: req0=1, d0=32'h8000_00F0, sa0=4, right0=1, arith0=1, out_ready=1 -> gnt0=1 that cycle; next cycle out_valid=1, out_sh=32'hF800_000F, out_id=0.
REQ-031 Modes on one operand: d=32'h8000_0001, sa=1 -> left 32'h0000_0002, logical right 32'h4000_0000, arithmetic right 32'hC000_0000; sa=0 -> 32'h8000_0001 in all three modes.
REQ-032 Contention with PRIO_INIT=0: req0 and req1 held high for 4 cycles with out_ready=1 -> grant order 0,1,0,1; out_id sequence 0,1,0,1, one result per cycle.
REQ-033 Backpressure: after the first result, out_ready=0 for 3 cycles with req1=1 -> gnt1=0 and out_sh/out_id stable for those cycles; out_ready=1 -> gnt1=1 the same cycle and the new result appears next cycle.
REQ-034 Reset mid-hold: out_valid=1 with out_ready=0, then reset=1 for one cycle -> out_valid=0, out_sh=0, out_id=0, no gnt during reset; prio returns to PRIO_INIT (verified by the next contention).
